// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with pending scoreboard and clear sequencer
// Optional write-through forwarding to the read ports when REGFILE_BYPASS_EN is defined.
module reg_file_sb #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic            wr_rdy,
  input  logic [AW-1:0]   rr1,
  input  logic [AW-1:0]   rr2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            rd1_pend,
  output logic            rd2_pend,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_rdy,
  input  logic            clr_req,
  output logic            clr_busy,
  output logic            clr_done
);
  localparam int NREGS = 1 << AW;
  localparam logic [AW-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t            state, state_nxt;
  logic [XLEN-1:0]   file [NREGS];
  logic [NREGS-1:0]  pend, pend_nxt;
  logic [AW-1:0]     idx;
  logic              wr_fire, iss_fire, clr_start;
  logic [XLEN-1:0]   st_rd1, st_rd2;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_rdy    = 1'b1;
    iss_rdy   = 1'b1;
    clr_busy  = 1'b0;
    clr_done  = 1'b0;
    clr_start = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          clr_start = 1'b1;
        end
      end
      CLEAR: begin
        wr_rdy   = 1'b0;
        iss_rdy  = 1'b0;
        clr_busy = 1'b1;
        if (idx == LAST_IDX) state_nxt = DONE;
      end
      DONE: begin
        clr_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_fire  = wr_en && wr_rdy && (wr_addr != '0);
  assign iss_fire = iss_en && iss_rdy && (iss_rd != '0);

  // Clear before set so a same-cycle issue to the written register stays pending.
  always_comb begin
    pend_nxt = pend;
    if (wr_fire)  pend_nxt[wr_addr] = 1'b0;
    if (iss_fire) pend_nxt[iss_rd]  = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n)       pend <= '0;
    else if (clr_start) pend <= '0;
    else                pend <= pend_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx <= '0;
    end else if (clr_start) begin
      idx <= {{(AW-1){1'b0}}, 1'b1};
    end else if (state == CLEAR && idx != LAST_IDX) begin
      idx <= idx + 1'b1;
    end
  end

  // wr_rdy is low during CLEAR, so the sequencer owns the write port there.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) file[i] <= '0;
    end else if (state == CLEAR) begin
      file[idx] <= '0;
    end else if (wr_fire) begin
      file[wr_addr] <= wr_data;
    end
  end

  assign st_rd1 = (rr1 == '0) ? '0 : file[rr1];
  assign st_rd2 = (rr2 == '0) ? '0 : file[rr2];

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rd1      = st_rd1;
    rd2      = st_rd2;
    rd1_pend = pend[rr1];
    rd2_pend = pend[rr2];
    if (wr_fire && rr1 == wr_addr) begin
      rd1      = wr_data;
      rd1_pend = iss_fire && (iss_rd == wr_addr);
    end
    if (wr_fire && rr2 == wr_addr) begin
      rd2      = wr_data;
      rd2_pend = iss_fire && (iss_rd == wr_addr);
    end
  end
`else
  assign rd1      = st_rd1;
  assign rd2      = st_rd2;
  assign rd1_pend = pend[rr1];
  assign rd2_pend = pend[rr2];
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - scoreboard bench for reg_file_sb against a behavioural model
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        reset_n, wr_en, iss_en, clr_req;
  logic [4:0]  wr_addr, rr1, rr2, iss_rd;
  logic [31:0] wr_data, rd1, rd2;
  logic        wr_rdy, rd1_pend, rd2_pend, iss_rdy, clr_busy, clr_done;

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
    .rr1(rr1), .rr2(rr2), .rd1(rd1), .rd2(rd2),
    .rd1_pend(rd1_pend), .rd2_pend(rd2_pend),
    .iss_en(iss_en), .iss_rd(iss_rd), .iss_rdy(iss_rdy),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  typedef struct {
    logic [31:0] rd1, rd2;
    logic        p1, p2, wr, is, busy, done;
  } exp_t;

  exp_t  eq[$];
  event  sample_ev;
  int    checks = 0, passed = 0;
  int    busy_cnt = 0, done_cnt = 0;

  // Behavioural model: array contents, pending flags, and a clear cursor.
  logic [31:0] m_file [32];
  bit          m_pend [32];
  bit          m_busy, m_done;
  int          m_pos;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_file[i] = '0;
      m_pend[i] = 0;
    end
    m_busy = 0;
    m_done = 0;
    m_pos  = 0;
  endtask

  function automatic exp_t predict();
    exp_t e;
    bit wfire, ifire;
    e.rd1  = (rr1 == 0) ? 32'h0 : m_file[rr1];
    e.rd2  = (rr2 == 0) ? 32'h0 : m_file[rr2];
    e.p1   = m_pend[rr1];
    e.p2   = m_pend[rr2];
    e.wr   = !m_busy;
    e.is   = !m_busy;
    e.busy = m_busy;
    e.done = m_done;
    wfire = wr_en && !m_busy && wr_addr != 0;
    ifire = iss_en && !m_busy && iss_rd != 0;
`ifdef REGFILE_BYPASS_EN
    if (wfire && rr1 == wr_addr) begin
      e.rd1 = wr_data;
      e.p1  = ifire && iss_rd == wr_addr;
    end
    if (wfire && rr2 == wr_addr) begin
      e.rd2 = wr_data;
      e.p2  = ifire && iss_rd == wr_addr;
    end
`endif
    return e;
  endfunction

  task automatic model_edge();
    if (!reset_n) begin
      model_reset();
    end else if (m_busy) begin
      m_file[m_pos] = '0;
      if (m_pos == 31) begin
        m_busy = 0;
        m_done = 1;
      end else begin
        m_pos++;
      end
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_file[wr_addr] = wr_data;
        m_pend[wr_addr] = 0;
      end
      if (iss_en && iss_rd != 0) m_pend[iss_rd] = 1;
      if (clr_req && !m_done) begin
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
        m_busy = 1;
        m_pos  = 1;
      end
      m_done = 0;
    end
  endtask

  // One clock: drive at negedge, predict, hand to the monitor, then advance the model.
  task automatic step(input bit rn, input bit we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] a1, input logic [4:0] a2,
                      input bit ie, input logic [4:0] ir, input bit cr, input bit check);
    @(negedge clk);
    reset_n = rn; wr_en = we; wr_addr = wa; wr_data = wd;
    rr1 = a1; rr2 = a2; iss_en = ie; iss_rd = ir; clr_req = cr;
    #1;
    if (check) begin
      eq.push_back(predict());
      ->sample_ev;
    end
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle_read(input logic [4:0] a1, input logic [4:0] a2);
    step(1, 0, 0, 0, a1, a2, 0, 0, 0, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(sample_ev);
      if (eq.size() == 0) begin
        chk("queue_empty", 1, 0);
      end else begin
        e = eq.pop_front();
        chk("rd1", rd1, e.rd1);
        chk("rd2", rd2, e.rd2);
        chk("rd1_pend", {31'b0, rd1_pend}, {31'b0, e.p1});
        chk("rd2_pend", {31'b0, rd2_pend}, {31'b0, e.p2});
        chk("wr_rdy", {31'b0, wr_rdy}, {31'b0, e.wr});
        chk("iss_rdy", {31'b0, iss_rdy}, {31'b0, e.is});
        chk("clr_busy", {31'b0, clr_busy}, {31'b0, e.busy});
        chk("clr_done", {31'b0, clr_done}, {31'b0, e.done});
        if (clr_busy) busy_cnt++;
        if (clr_done) done_cnt++;
      end
    end
  end

  initial begin : stim
    model_reset();
    reset_n = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    rr1 = 0; rr2 = 0; iss_en = 0; iss_rd = 0; clr_req = 0;

    // Reset, then x5 write and readback.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 5, 0, 0, 0, 0, 1);
    step(1, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0, 1);
    idle_read(5, 0);

    // Write to x0 is discarded.
    step(1, 1, 0, 32'hFFFFFFFF, 0, 5, 1, 0, 0, 1);
    idle_read(0, 0);

    // Issue/writeback collision on x7: set wins.
    step(1, 0, 0, 0, 7, 7, 1, 7, 0, 1);
    step(1, 1, 7, 32'h12, 7, 7, 1, 7, 0, 1);
    idle_read(7, 7);
    step(1, 1, 7, 32'h34, 7, 0, 0, 0, 0, 1);
    idle_read(7, 0);

    // Bypass window on x9.
    step(1, 1, 9, 32'h11111111, 9, 9, 0, 0, 0, 1);
    step(1, 1, 9, 32'hA5A5A5A5, 9, 9, 0, 0, 0, 1);
    idle_read(9, 9);

    // Fill x1..x31, mark a few pending, then a full clear with writes attempted while busy.
    for (int i = 1; i < 32; i++) step(1, 1, 5'(i), 32'(i), 5'(i), 5'(i - 1), 0, 0, 0, 1);
    for (int i = 3; i < 32; i += 7) step(1, 0, 0, 0, 5'(i), 5'(i), 1, 5'(i), 0, 1);
    busy_cnt = 0; done_cnt = 0;
    step(1, 0, 0, 0, 3, 10, 0, 0, 1, 1);
    for (int c = 0; c < 33; c++)
      step(1, 1, 5'($urandom_range(1, 31)), $urandom, 5'(c), 5'(31 - c), 1, 5'($urandom_range(1, 31)), 0, 1);
    @(negedge clk);
    chk("busy_cycles", busy_cnt, 31);
    chk("done_pulses", done_cnt, 1);
    for (int i = 0; i < 32; i += 2) idle_read(5'(i), 5'(i + 1));

    // Reset in the middle of a clear.
    for (int i = 1; i < 32; i++) step(1, 1, 5'(i), 32'hC0DE0000 | i, 0, 0, 0, 0, 0, 1);
    busy_cnt = 0; done_cnt = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int c = 0; c < 9; c++) step(1, 0, 0, 0, 20, 30, 0, 0, 0, 1);
    step(0, 0, 0, 0, 20, 30, 0, 0, 0, 1);
    for (int c = 0; c < 4; c++) idle_read(20, 30);
    @(negedge clk);
    chk("abort_done_pulses", done_cnt, 0);
    for (int i = 0; i < 32; i += 2) idle_read(5'(i), 5'(i + 1));

    // Held clr_req re-triggers after DONE; then random traffic.
    for (int c = 0; c < 36; c++) step(1, 0, 0, 0, 1, 2, 0, 0, 1, 1);
    for (int c = 0; c < 400; c++) begin
      logic [4:0] wa, ir;
      wa = ($urandom % 2) ? 5'($urandom % 8) : 5'($urandom);
      ir = ($urandom % 2) ? 5'($urandom % 8) : 5'($urandom);
      step(($urandom % 80) != 0, $urandom % 2, wa, $urandom,
           ($urandom % 2) ? wa : 5'($urandom), 5'($urandom % 8),
           $urandom % 2, ir, ($urandom % 60) == 0, 1);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", eq.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
